fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Produces the operand-forwarding selects (fa, fb) that drive the ALU input-A/B muxes, plus the load-use stall.
//  Keeps a shadow pipeline of destination info for the EX, MEM and WB stages.
//  Sits beside the mips pipeline and is fed from the ID stage; its fa/fb are registered so they are valid
//  for the whole EX cycle of the instruction they belong to.
// PARAMETERS
//  STALL_CNT_W  16  width of saturating load-use stall-cycle counter
//  FWD_R0       0   1 = allow forwarding of register 0; 0 = r0 never forwarded (always 00)
// PORTS
//  clock       in   1   single clock, rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  id_valid    in   1   ID stage holds a real instruction
//  id_op       in   6   opcode of the ID instruction
//  id_rs       in   5   rs field of the ID instruction
//  id_rt       in   5   rt field of the ID instruction
//  id_rd       in   5   rd field of the ID instruction
//  flush       in   1   squash the ID and EX instructions (taken branch/jump)
//  fa          out  2   forward select for ALU A: 00 IDEXA, 01 MEMWBValue, 10 EXMEMALUOut
//  fb          out  2   forward select for ALU B: 00 IDEXB/imm, 01 MEMWBValue, 10 EXMEMALUOut
//  stall       out  1   comb.; freeze PC and IF/ID, inject a bubble into ID/EX
//  stall_cnt   out  STALL_CNT_W  count of stall cycles asserted, saturating
// BEHAVIOUR
//  Decode per stage: wr = op in {ALUop, LW, ADD_IMM, JALop}; dst = rd (ALUop), rt (LW, ADD_IMM), 31 (JALop).
//  Also: ld = (op==LW); use_rs = op in {ALUop, LW, SW, ADD_IMM, BEQ}; use_rt = op in {ALUop, SW, BEQ}.
//  Shadow regs: EX{v,wr,ld,dst} -> MEM{v,wr,ld,dst} -> WB{v,wr,dst}; advance every clock.
//  EX captures ID when id_valid & !stall & !flush; otherwise EX captures a bubble (v=0).
//  A match against stage S requires S.v & S.wr & (S.dst!=0 | FWD_R0) & (src==S.dst).
//  fb update at the clock edge when the ID instruction moves into EX, priority top-down:
//    - matches the current EX entry (which becomes EX/MEM) and that entry is not a load -> 10
//    - else matches the current MEM entry (which becomes MEM/WB) -> 01
//    - else -> 00
//  fa is computed the same way on id_rs.
//  On a bubble edge, fa and fb are loaded with 00. Code 11 is never driven.
//  Load-use: stall = id_valid & !flush & EX.v & EX.ld & ((use_rs & rs matches EX) | (use_rt & rt matches EX)).
//    Exactly one stall cycle. The dependent op then gets 01 (load value from MEM/WB).
//  Flush: EX shadow and fa/fb cleared at the edge; MEM/WB unaffected. flush & stall cannot both be 1 (flush wins).
//  Double match (EX and MEM both write the source register): the younger (EX, code 10) wins.
//  stall_cnt: +1 per cycle with stall=1; holds at all-ones.
//  Reset: async on reset_n low. All shadow v=0, fa=fb=00, stall_cnt=0; stall reads 0 because EX.v=0.
//    Reset mid-stall drops stall immediately.
//  Latency: fa/fb are registered, 1 clock after ID; stall is combinational, same cycle.
// STRUCTURE
//  Package mips_pkg holds:
//    - opcodes ALUop=6'd0, Jop=6'd2, JALop=6'd3, BEQ=6'd4, ADD_IMM=6'd8, LW=6'd35, SW=6'd43
//    - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
//    - REG_RA=5'd31
//  One sub-module, fwd_decode (comb.): op/rs/rt/rd -> wr, ld, dst, use_rs, use_rt. Instantiated for ID.
// TESTING
//  1. add r3,r1,r2 ; add r4,r3,r5 back-to-back -> 2nd in EX: fa=10, fb=00, stall=0.
//  2. add r3,.. ; nop ; sub r6,r5,r3 -> sub in EX: fb=01, fa=00.
//  3. lw r7,0(r1) ; add r8,r7,r2 -> stall=1 for exactly 1 cycle, bubble fa=fb=00, then fa=01; stall_cnt=1.
//  4. add r0,r1,r2 ; add r4,r0,r0 -> fa=fb=00 (FWD_R0=0); addi r5,r1,4 ; add r6,r5,r5 -> fa=fb=10.
//  5. flush with dependent ID/EX pair -> EX bubble, fa=fb=00.
//     reset_n low mid-stall -> stall=0, stall_cnt=0 asynchronously.
//  6. Force 2^16+3 load-use stalls -> stall_cnt saturates at 16'hFFFF.
//     add r3 ; add r3 ; add r9,r3,r3 -> fa=fb=10 (younger wins).

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, forward-select codes and register constants shared by the hazard unit
package mips_pkg;

  localparam logic [5:0] ALUop   = 6'd0;
  localparam logic [5:0] Jop     = 6'd2;
  localparam logic [5:0] JALop   = 6'd3;
  localparam logic [5:0] BEQ     = 6'd4;
  localparam logic [5:0] ADD_IMM = 6'd8;
  localparam logic [5:0] LW      = 6'd35;
  localparam logic [5:0] SW      = 6'd43;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // A load sitting in EX cannot feed EX/MEM; its value is only usable one stage later.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_ld, input logic mem_hit);
    if (ex_hit && !ex_ld) return FWD_MEM;
    if (mem_hit)          return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/fwd_decode.sv
// rtl/fwd_decode.sv - combinational decode of destination and source usage for one instruction
module fwd_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic       wr,
  output logic       ld,
  output logic [4:0] dst,
  output logic       use_rs,
  output logic       use_rt
);

  always_comb begin
    wr     = 1'b0;
    ld     = 1'b0;
    dst    = rt;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (op)
      ALUop: begin
        wr     = 1'b1;
        dst    = rd;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      LW: begin
        wr     = 1'b1;
        ld     = 1'b1;
        use_rs = 1'b1;
      end
      ADD_IMM: begin
        wr     = 1'b1;
        use_rs = 1'b1;
      end
      JALop: begin
        wr  = 1'b1;
        dst = REG_RA;
      end
      SW, BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - registered ALU forward selects and load-use stall from a shadow EX/MEM pipeline
module fwd_hazard_unit #(
  parameter int unsigned STALL_CNT_W = 16,
  parameter bit          FWD_R0      = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   id_valid,
  input  logic [5:0]             id_op,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [4:0]             id_rd,
  input  logic                   flush,
  output logic [1:0]             fa,
  output logic [1:0]             fb,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  import mips_pkg::*;

  logic       id_wr, id_ld, id_use_rs, id_use_rt;
  logic [4:0] id_dst;

  fwd_decode u_id_decode (
    .op     (id_op),
    .rt     (id_rt),
    .rd     (id_rd),
    .wr     (id_wr),
    .ld     (id_ld),
    .dst    (id_dst),
    .use_rs (id_use_rs),
    .use_rt (id_use_rt)
  );

  // No WB shadow is held: forwarding only ever looks at EX/MEM and MEM/WB.
  logic       ex_v, ex_wr, ex_ld;
  logic [4:0] ex_dst;
  logic       mem_v, mem_wr;
  logic [4:0] mem_dst;

  function automatic logic hit(input logic v, input logic w, input logic [4:0] dst, input logic [4:0] src);
    return v && w && ((dst != REG_ZERO) || FWD_R0) && (src == dst);
  endfunction

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, take;

  assign ex_hit_rs  = hit(ex_v, ex_wr, ex_dst, id_rs);
  assign ex_hit_rt  = hit(ex_v, ex_wr, ex_dst, id_rt);
  assign mem_hit_rs = hit(mem_v, mem_wr, mem_dst, id_rs);
  assign mem_hit_rt = hit(mem_v, mem_wr, mem_dst, id_rt);

  assign stall = id_valid && !flush && ex_v && ex_ld &&
                 ((id_use_rs && ex_hit_rs) || (id_use_rt && ex_hit_rt));
  assign take  = id_valid && !stall && !flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_v      <= 1'b0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_dst    <= REG_ZERO;
      mem_v     <= 1'b0;
      mem_wr    <= 1'b0;
      mem_dst   <= REG_ZERO;
      fa        <= FWD_REG;
      fb        <= FWD_REG;
      stall_cnt <= '0;
    end else begin
      mem_v   <= ex_v;
      mem_wr  <= ex_wr;
      mem_dst <= ex_dst;
      ex_v    <= take;
      ex_wr   <= take && id_wr;
      ex_ld   <= take && id_ld;
      ex_dst  <= id_dst;
      fa      <= take ? fwd_sel(ex_hit_rs, ex_ld, mem_hit_rs) : FWD_REG;
      fb      <= take ? fwd_sel(ex_hit_rt, ex_ld, mem_hit_rt) : FWD_REG;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed and random checks of fwd_hazard_unit against an instruction-level model
module tb_fwd_hazard_unit;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        id_valid, flush;
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  fa, fb, fa_s, fb_s;
  logic        stall, stall_s;
  logic [15:0] stall_cnt;
  logic [7:0]  stall_cnt_s;

  fwd_hazard_unit dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .fa(fa), .fb(fb), .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.STALL_CNT_W(8)) dut_s (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .fa(fa_s), .fb(fb_s), .stall(stall_s), .stall_cnt(stall_cnt_s)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: the two instructions ahead of ID, youngest first, kept as whole instructions.
  typedef struct {
    bit         v;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
  } ins_t;

  ins_t       pipe [2];
  logic [1:0] m_fa, m_fb;
  int         m_cnt, m_cnt8;

  function automatic bit writes(input logic [5:0] op);
    return op inside {ALUop, LW, ADD_IMM, JALop};
  endfunction

  function automatic logic [4:0] dest(input ins_t i);
    if (i.op == ALUop) return i.rd;
    if (i.op == JALop) return 5'd31;
    return i.rt;
  endfunction

  function automatic bit produces(input ins_t p, input logic [4:0] r);
    return p.v && writes(p.op) && dest(p) != 5'd0 && dest(p) == r;
  endfunction

  function automatic logic [1:0] pick(input logic [4:0] r);
    if (produces(pipe[0], r) && pipe[0].op != LW) return 2'b10;
    if (produces(pipe[1], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit rs_used, rt_used;
    if (!id_valid || flush || !pipe[0].v || pipe[0].op != LW) return 1'b0;
    rs_used = id_op inside {ALUop, LW, SW, ADD_IMM, BEQ};
    rt_used = id_op inside {ALUop, SW, BEQ};
    return (rs_used && produces(pipe[0], id_rs)) || (rt_used && produces(pipe[0], id_rt));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) pipe[i] = '{v: 1'b0, op: 6'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
    m_fa = 2'b00;
    m_fb = 2'b00;
    m_cnt = 0;
    m_cnt8 = 0;
  endtask

  // Called just after a rising edge: drive ID, check at the falling edge, advance model at the next edge.
  task automatic step(input bit a_v, input logic [5:0] a_op, input logic [4:0] a_rs,
                      input logic [4:0] a_rt, input logic [4:0] a_rd, input bit a_fl, output bit st);
    bit         take;
    logic [1:0] nfa, nfb;
    id_valid = a_v; id_op = a_op; id_rs = a_rs; id_rt = a_rt; id_rd = a_rd; flush = a_fl;
    @(negedge clock);
    st = m_stall();
    chk("stall", 32'(stall), 32'(st));
    chk("stall_s", 32'(stall_s), 32'(st));
    chk("fa", 32'(fa), 32'(m_fa));
    chk("fb", 32'(fb), 32'(m_fb));
    chk("fa_s", 32'(fa_s), 32'(m_fa));
    chk("fb_s", 32'(fb_s), 32'(m_fb));
    chk("stall_cnt", 32'(stall_cnt), m_cnt);
    chk("stall_cnt_s", 32'(stall_cnt_s), m_cnt8);
    @(posedge clock);
    take = a_v && !st && !a_fl;
    nfa = take ? pick(a_rs) : 2'b00;
    nfb = take ? pick(a_rt) : 2'b00;
    pipe[1] = pipe[0];
    if (take) pipe[0] = '{v: 1'b1, op: a_op, rs: a_rs, rt: a_rt, rd: a_rd};
    else      pipe[0] = '{v: 1'b0, op: 6'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
    m_fa = nfa;
    m_fb = nfb;
    if (st && m_cnt < 65535) m_cnt++;
    if (st && m_cnt8 < 255)  m_cnt8++;
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    bit st;
    step(1'b1, ALUop, rs, rt, rd, 1'b0, st);
  endtask

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(9) == 0) return 5'd31;
    return 5'($urandom_range(0, 4));
  endfunction

  logic [5:0] ops [8];

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit st;
    int c0, stalls;
    bit r_v;
    logic [5:0] r_op;
    logic [4:0] r_rs, r_rt, r_rd;

    ops = '{ALUop, LW, SW, ADD_IMM, BEQ, Jop, JALop, 6'd13};
    reset_n = 1'b0;
    id_valid = 1'b0; flush = 1'b0; id_op = 6'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    model_reset();
    #3;
    chk("rst_fa", 32'(fa), 32'd0);
    chk("rst_fb", 32'(fb), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    #9 reset_n = 1'b1;
    @(posedge clock); #1;

    // back-to-back ALU dependency
    alu(3, 1, 2); alu(4, 3, 5);
    chk("t1_fa", 32'(fa), 32'h2);
    chk("t1_fb", 32'(fb), 32'h0);

    // dependency two apart
    alu(3, 1, 2); alu(0, 0, 0); alu(6, 5, 3);
    chk("t2_fa", 32'(fa), 32'h0);
    chk("t2_fb", 32'(fb), 32'h1);

    // load-use
    c0 = m_cnt;
    step(1'b1, LW, 5'd1, 5'd7, 5'd0, 1'b0, st);
    step(1'b1, ALUop, 5'd7, 5'd2, 5'd8, 1'b0, st);
    chk("t3_bubble_fa", 32'(fa), 32'h0);
    chk("t3_bubble_fb", 32'(fb), 32'h0);
    chk("t3_cnt", 32'(stall_cnt), c0 + 1);
    step(1'b1, ALUop, 5'd7, 5'd2, 5'd8, 1'b0, st);
    chk("t3_fa", 32'(fa), 32'h1);
    chk("t3_cnt_hold", 32'(stall_cnt), c0 + 1);

    // r0 is never forwarded; immediate result is
    alu(0, 1, 2); alu(4, 0, 0);
    chk("t4_r0_fa", 32'(fa), 32'h0);
    chk("t4_r0_fb", 32'(fb), 32'h0);
    step(1'b1, ADD_IMM, 5'd1, 5'd5, 5'd0, 1'b0, st);
    alu(6, 5, 5);
    chk("t4_fa", 32'(fa), 32'h2);
    chk("t4_fb", 32'(fb), 32'h2);

    // flush squashes the dependent ID instruction
    alu(3, 1, 2);
    step(1'b1, ALUop, 5'd3, 5'd3, 5'd4, 1'b1, st);
    chk("t5_fa", 32'(fa), 32'h0);
    chk("t5_fb", 32'(fb), 32'h0);

    // asynchronous reset while a stall is asserted
    step(1'b1, LW, 5'd1, 5'd7, 5'd0, 1'b0, st);
    id_valid = 1'b1; id_op = ALUop; id_rs = 5'd7; id_rt = 5'd2; id_rd = 5'd8; flush = 1'b0;
    @(negedge clock);
    chk("t5_pre_stall", 32'(stall), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_stall", 32'(stall), 32'h0);
    chk("t5_rst_cnt", 32'(stall_cnt), 32'h0);
    model_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
    id_valid = 1'b0;

    // saturation on the 8-bit counter, exact count on the 16-bit one
    stalls = 0;
    for (int i = 0; i < 2000 && stalls < 259; i++) begin
      step(1'b1, LW, 5'd7, 5'd7, 5'd0, 1'b0, st);
      if (st) stalls++;
    end
    chk("t6_sat8", 32'(stall_cnt_s), 32'hFF);
    chk("t6_cnt16", 32'(stall_cnt), 32'd259);

    // younger producer wins
    alu(3, 1, 2); alu(3, 1, 2); alu(9, 3, 3);
    chk("t6_young_fa", 32'(fa), 32'h2);
    chk("t6_young_fb", 32'(fb), 32'h2);

    // random traffic; a stalled ID instruction is held, as IF/ID would be
    st = 1'b0;
    r_v = 1'b0; r_op = 6'd0; r_rs = 5'd0; r_rt = 5'd0; r_rd = 5'd0;
    for (int i = 0; i < 2000; i++) begin
      if (!st) begin
        r_v  = ($urandom_range(9) != 0);
        r_op = ops[$urandom_range(7)];
        r_rs = rand_reg();
        r_rt = rand_reg();
        r_rd = rand_reg();
      end
      step(r_v, r_op, r_rs, r_rt, r_rd, ($urandom_range(9) == 0), st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
